// File: rtl/flex_stp_word_sr.sv
// flex_stp_word_sr
//   Serial-to-parallel shift register with built-in word framing. It counts
//   shifted bits, and every NUM_BITS shifts it copies the assembled word into
//   a holding register and raises data_ready. data_ready stays high until the
//   consumer acknowledges with data_read. A word that completes while the
//   previous word is still unread sets the sticky overrun flag.
//
// Parameters
//   NUM_BITS  : word width and bits per frame (2..32)
//   SHIFT_MSB : 1 = new bit enters at bit 0 (MSB-first stream)
//               0 = new bit enters at MSB   (LSB-first stream)
//   RESET_BIT : fill value of the shift register on reset or clear
//
// Ports
//   clk, n_rst    : clock (rising edge) and asynchronous active-low reset
//   shift_enable  : shift serial_in in this cycle
//   serial_in     : serial data bit
//   clear         : synchronous frame abort; overrides shift_enable and data_read
//   data_read     : consumer acknowledge of data_out
//   parallel_out  : live shift-register contents
//   data_out      : last completed word
//   data_ready    : data_out holds an unread word
//   word_done     : one-cycle pulse per completed word
//   overrun       : sticky; a word completed while the previous one was unread
//   bit_count     : bits shifted into the current frame (0..NUM_BITS-1)
module flex_stp_word_sr #(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b1,
  parameter bit          RESET_BIT = 1'b1
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            shift_enable,
  input  logic                            serial_in,
  input  logic                            clear,
  input  logic                            data_read,
  output logic [NUM_BITS-1:0]             parallel_out,
  output logic [NUM_BITS-1:0]             data_out,
  output logic                            data_ready,
  output logic                            word_done,
  output logic                            overrun,
  output logic [$clog2(NUM_BITS+1)-1:0]   bit_count
);

  localparam int unsigned CW = $clog2(NUM_BITS + 1);
  localparam logic [NUM_BITS-1:0] FILL = {NUM_BITS{RESET_BIT}};
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] shifted;
  logic                complete;

  // Value the register takes if this cycle shifts; also the captured word
  // when this shift completes the frame.
  always_comb begin
    shifted = parallel_out;
    if (SHIFT_MSB) begin
      shifted = {parallel_out[NUM_BITS-2:0], serial_in};
    end else begin
      shifted = {serial_in, parallel_out[NUM_BITS-1:1]};
    end
  end

  assign complete = shift_enable && (bit_count == LAST_BIT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out <= FILL;
      bit_count    <= '0;
    end else if (clear) begin
      parallel_out <= FILL;
      bit_count    <= '0;
    end else if (shift_enable) begin
      parallel_out <= shifted;
      bit_count    <= complete ? '0 : bit_count + CW'(1);
    end
  end

  // Completion takes precedence over an acknowledge on the same edge: the
  // new word is unread, so data_ready stays set and no overrun is flagged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_out   <= '0;
      data_ready <= 1'b0;
      word_done  <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      data_ready <= 1'b0;
      word_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      word_done <= complete;
      if (complete) begin
        data_out   <= shifted;
        data_ready <= 1'b1;
        if (data_ready && !data_read) begin
          overrun <= 1'b1;
        end
      end else if (data_read) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flex_stp_word_sr.sv
// tb_flex_stp_word_sr
//   Bench for flex_stp_word_sr. Two instances (MSB-first and LSB-first) share
//   one stimulus stream. The reference model keeps the history of received
//   bits and rebuilds words from it; framing, handshake and overrun follow
//   the behavioural rules directly.
module tb_flex_stp_word_sr;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N + 1);
  localparam bit          FILL_BIT = 1'b1;

  logic clk = 1'b0;
  logic n_rst, shift_enable, serial_in, clear, data_read;

  logic [N-1:0]  po_m, po_l, dout_m, dout_l;
  logic          rdy_m, rdy_l, wd_m, wd_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  always #5 clk = ~clk;

  flex_stp_word_sr #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .RESET_BIT(FILL_BIT)) dut_m (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .data_read(data_read), .parallel_out(po_m), .data_out(dout_m),
    .data_ready(rdy_m), .word_done(wd_m), .overrun(ovr_m), .bit_count(cnt_m)
  );

  flex_stp_word_sr #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .RESET_BIT(FILL_BIT)) dut_l (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .data_read(data_read), .parallel_out(po_l), .data_out(dout_l),
    .data_ready(rdy_l), .word_done(wd_l), .overrun(ovr_l), .bit_count(cnt_l)
  );

  // ---------------- reference model ----------------
  bit           hist[$];   // bits received since last reset/clear, newest last
  int           m_cnt;
  bit           m_rdy, m_wd, m_ovr;
  logic [N-1:0] m_dout_m, m_dout_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Register contents as the most recent N bits of history (fill where the
  // history is shorter). MSB-first: newest bit at bit 0; LSB-first: at bit N-1.
  function automatic logic [N-1:0] word_of(bit msb_first);
    logic [N-1:0] w;
    int idx;
    bit b;
    w = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx = hist.size() - 1 - i;
      b = (idx >= 0) ? hist[idx] : FILL_BIT;
      if (msb_first) w[i] = b;
      else           w[N-1-i] = b;
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt = 0; m_rdy = 0; m_wd = 0; m_ovr = 0;
    m_dout_m = '0; m_dout_l = '0;
  endtask

  task automatic model_step(bit se, bit si, bit clr, bit rd);
    if (clr) begin
      hist.delete();
      m_cnt = 0; m_rdy = 0; m_ovr = 0; m_wd = 0;
    end else begin
      m_wd = 0;
      if (se) begin
        hist.push_back(si);
        if (hist.size() > int'(N)) void'(hist.pop_front());
        m_cnt++;
      end
      if (se && m_cnt == int'(N)) begin
        m_cnt = 0;
        m_wd = 1;
        m_dout_m = word_of(1'b1);
        m_dout_l = word_of(1'b0);
        if (m_rdy && !rd) m_ovr = 1;
        m_rdy = 1;
      end else if (rd) begin
        m_rdy = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("po_m",   32'(po_m),   32'(word_of(1'b1)));
    chk("po_l",   32'(po_l),   32'(word_of(1'b0)));
    chk("dout_m", 32'(dout_m), 32'(m_dout_m));
    chk("dout_l", 32'(dout_l), 32'(m_dout_l));
    chk("rdy_m",  32'(rdy_m),  32'(m_rdy));
    chk("rdy_l",  32'(rdy_l),  32'(m_rdy));
    chk("wd_m",   32'(wd_m),   32'(m_wd));
    chk("wd_l",   32'(wd_l),   32'(m_wd));
    chk("ovr_m",  32'(ovr_m),  32'(m_ovr));
    chk("ovr_l",  32'(ovr_l),  32'(m_ovr));
    chk("cnt_m",  32'(cnt_m),  32'(m_cnt));
    chk("cnt_l",  32'(cnt_l),  32'(m_cnt));
  endtask

  // One clock: drive inputs, advance model at the edge, check at negedge.
  task automatic cyc(bit se, bit si, bit clr, bit rd);
    shift_enable = se; serial_in = si; clear = clr; data_read = rd;
    @(posedge clk);
    model_step(se, si, clr, rd);
    @(negedge clk);
    check_all();
  endtask

  // Send a whole byte; msb picks bit order, gap adds idle cycles after each
  // bit, rd_last raises data_read on the final bit's cycle.
  task automatic send_word(logic [7:0] w, bit msb, int gap, bit rd_last);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, msb ? w[7-i] : w[i], 1'b0, rd_last && (i == 7));
      if (i < 7) for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; data_read = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("reset_po_ff", 32'(po_m), 32'hFF);
    n_rst = 1'b1;

    // MSB-first 0xA5, consecutive bits
    send_word(8'hA5, 1'b1, 0, 1'b0);
    chk("a5_dout", 32'(dout_m), 32'hA5);
    chk("a5_wd",   32'(wd_m),   32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_wd_one_cycle", 32'(wd_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first 0x3C with two idle cycles between bits
    send_word(8'h3C, 1'b0, 2, 1'b0);
    chk("3c_dout_l", 32'(dout_l), 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // overrun: 0x11 unread, then 0x22
    send_word(8'h11, 1'b1, 0, 1'b0);
    send_word(8'h22, 1'b1, 0, 1'b0);
    chk("ovr_dout", 32'(dout_m), 32'h22);
    chk("ovr_set",  32'(ovr_m),  32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_sticky", 32'(ovr_m), 32'h1);
    chk("ovr_rdy0",   32'(rdy_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr", 32'(ovr_m), 32'h0);

    // read on the same edge as the second completion
    send_word(8'h5A, 1'b1, 0, 1'b0);
    send_word(8'h96, 1'b1, 0, 1'b1);
    chk("sim_rdy",  32'(rdy_m),  32'h1);
    chk("sim_ovr",  32'(ovr_m),  32'h0);
    chk("sim_dout", 32'(dout_m), 32'h96);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // clear mid-frame, together with shift_enable
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt",  32'(cnt_m),  32'h0);
    chk("clr_po",   32'(po_m),   32'hFF);
    chk("clr_dout", 32'(dout_m), 32'h96);
    send_word(8'hC3, 1'b1, 0, 1'b0);
    chk("clr_next", 32'(dout_m), 32'hC3);

    // async reset between edges after 3 bits
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    shift_enable = 1'b0; data_read = 1'b0;
    #1 n_rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("arst_po", 32'(po_m), 32'hFF);
    #1 n_rst = 1'b1;
    send_word(8'h7E, 1'b1, 0, 1'b0);
    chk("arst_next", 32'(dout_m), 32'h7E);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
